unidad_busqueda: RTL and testbench
==================================

UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

Interface
REQ-001 SHALL have parameter RESET_PC, default 5'd0: first fetch address after reset.
REQ-002 SHALL have parameter JUMP_OP, default 6'b111110: opcode in bits [31:26] of a relative jump.
REQ-003 SHALL have parameter HALT_WORD, default 32'h0000_0000: instruction word that stops fetching.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high, sampled on rising clk.
REQ-006 SHALL have port run  input  1  level start; leaves IDLE when 1.
REQ-007 SHALL have port direinstru  output  5  instruction-memory address, equal to the PC register.
REQ-008 SHALL have port instru  input  32  instruction-memory read data, combinational from direinstru.
REQ-009 SHALL have port instr_out  output  32  registered instruction issued to decode.
REQ-010 SHALL have port instr_valid  output  1  instr_out holds an issued instruction.
REQ-011 SHALL have port instr_ready  input  1  decode accepts instr_out this cycle.
REQ-012 SHALL have port redirect_valid  input  1  external PC redirect, from the branch unit.
REQ-013 SHALL have port redirect_addr  input  5  redirect target.
REQ-014 SHALL have port halted  output  1  high while in HALT.
REQ-015 SHALL have port fetch_count  output  16  number of instructions issued since reset, saturating at 16'hFFFF.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALT.
REQ-017 IDLE -> FETCH when run=1; PC is held in IDLE.
REQ-018 In FETCH, the output slot is free when instr_valid=0 or instr_ready=1; the handshake fires when instr_valid and instr_ready are both 1.
REQ-019 When the slot is free, the block SHALL capture instru into instr_out, set instr_valid=1 on the next edge, and advance PC. Latency is 1 cycle from address to valid.
REQ-020 When the slot is not free, instr_out, instr_valid and PC SHALL hold.
REQ-021 Sequential next PC SHALL be PC+1 modulo 32; 31 wraps to 0 with no flag.
REQ-022 A captured word equal to HALT_WORD SHALL NOT be issued; instead instr_valid <= 0, the FSM moves to HALT, and PC holds.
REQ-023 HALT SHALL be exited only by reset; halted=1 only in HALT, and redirect and run are ignored there.
REQ-024 If redirect_valid=1 in FETCH or IDLE, PC <= redirect_addr and instr_valid <= 0 (flush). Redirect has priority over capture, over the handshake, and over the jump/halt decode in the same cycle.
REQ-025 A redirect in IDLE does not start fetching.
REQ-026 fetch_count SHALL increment on each issue, i.e. on each capture of a non-halt, non-consumed-jump word, and saturate.

Reset
REQ-027 While reset=1: PC <= RESET_PC, state <= IDLE, instr_out <= 0, instr_valid <= 0, halted <= 0, fetch_count <= 0.
REQ-028 Reset mid-operation SHALL discard any held instruction with no handshake completion.
REQ-029 After reset, the instruction memory is valid because it loads its contents during reset; the first fetch occurs no earlier than the first edge after reset deasserts with run=1.

Configuration
REQ-030 With macro FETCH_RELATIVE_JUMP_EN defined, a captured word with [31:26]==JUMP_OP SHALL NOT be issued. PC <= PC + sign-extended instru[4:0], modulo 32, instr_valid <= 0, and fetch_count is unchanged.
REQ-031 Without FETCH_RELATIVE_JUMP_EN, jump words SHALL be issued like any other word, with PC+1; the jump decode logic is absent.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the FSM state typedef, the JUMP_OP and HALT_WORD default constants, and the 5-bit address typedef.
REQ-033 Next-PC selection (redirect / jump / sequential) SHALL be a combinational sub-module fetch_next_pc; FSM and registers stay in unidad_busqueda.

Verification
REQ-034 Reset, then run=1, instr_ready=1, memory with words 1..5 at addresses 0..4 -> instr_out 1,2,3,4,5 on consecutive cycles starting 1 cycle after the FETCH entry; fetch_count=5.
REQ-035 instr_ready=0 for 3 cycles with instr_valid=1 -> instr_out and direinstru stable; after ready returns, the next word follows with no loss or duplication.
REQ-036 With FETCH_RELATIVE_JUMP_EN, jump at address 3 with imm=+2 -> address 5 is fetched, the jump is not issued, address 4 is skipped. Imm=-3 (5'b11101) at address 1 -> target 30.
REQ-037 redirect_valid=1, redirect_addr=20, in the same cycle as a handshake with a jump captured -> next direinstru=20, instr_valid=0, fetch_count unchanged.
REQ-038 HALT_WORD at address 9 -> halted=1 with instr_valid=0 from the following cycle, PC stays 9, redirect ignored; reset returns the block to IDLE with PC=0. Sequential fetch across address 31 -> next address 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
// The optional relative-jump decode is enabled with FETCH_RELATIVE_JUMP_EN.
package fetch_pkg;

  // 5-bit instruction-memory address
  typedef logic [4:0] addr_t;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_HALT  = 2'd2;

  // Default opcode of a PC-relative jump and the word that stops fetching
  localparam logic [5:0]  JUMP_OP_DEFAULT   = 6'b111110;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: redirect beats jump, jump beats sequential.
// Address arithmetic is 5 bits wide, so both PC+1 and PC+imm wrap modulo 32.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  addr_t      pc,
  input  logic       redirect_valid,
  input  addr_t      redirect_addr,
  input  logic       jump_taken,
  input  logic [4:0] jump_imm,
  output addr_t      next_pc
);

  // Pick the highest-priority source for the next fetch address
  always_comb begin
    next_pc = pc + 5'd1;
    if (jump_taken) begin
      next_pc = pc + jump_imm;
    end
    if (redirect_valid) begin
      next_pc = redirect_addr;
    end
  end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: IDLE/FETCH/HALT FSM, PC, one-entry output slot with
// valid/ready handshake and a saturating issue counter.
// Optional feature: FETCH_RELATIVE_JUMP_EN consumes relative jumps in fetch.
module unidad_busqueda
  import fetch_pkg::*;
#(
  parameter addr_t       RESET_PC  = 5'd0,
  parameter logic [5:0]  JUMP_OP   = JUMP_OP_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [4:0]  direinstru,
  input  logic [31:0] instru,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [4:0]  redirect_addr,
  output logic        halted,
  output logic [15:0] fetch_count
);

  state_t      state_q, state_d;
  addr_t       pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic  slot_free;
  logic  is_halt;
  logic  jump_taken;
  addr_t next_pc;

  assign slot_free = !valid_q || instr_ready;
  assign is_halt   = (instru == HALT_WORD);

`ifdef FETCH_RELATIVE_JUMP_EN
  assign jump_taken = (instru[31:26] == JUMP_OP);
`else
  assign jump_taken = 1'b0;
`endif

  fetch_next_pc u_next_pc (
    .pc             (pc_q),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .jump_taken     (jump_taken),
    .jump_imm       (instru[4:0]),
    .next_pc        (next_pc)
  );

  // FSM and datapath next-state; redirect wins over capture, handshake and decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
        end else if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
        end else if (slot_free) begin
          if (is_halt) begin
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else if (jump_taken) begin
            pc_d    = next_pc;
            valid_d = 1'b0;
          end else begin
            instr_d = instru;
            valid_d = 1'b1;
            pc_d    = next_pc;
            if (count_q != 16'hFFFF) begin
              count_d = count_q + 16'd1;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign direinstru  = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed self-checking bench for unidad_busqueda with a 32-word instruction
// memory model. Jump-specific steps follow FETCH_RELATIVE_JUMP_EN.
module tb_unidad_busqueda;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [4:0]  direinstru;
  logic [31:0] instru;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [32];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign instru = mem[direinstru];

  unidad_busqueda dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .direinstru     (direinstru),
    .instru         (instru),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] jword(input logic [4:0] imm);
    return {6'b111110, 21'd0, imm};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i + 1;
    reset = 1'b1; run = 1'b0; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_addr = 5'd0;

    // Reset state
    tick(); tick();
    check("rst_pc", 32'(direinstru), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_out", instr_out, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);

    // IDLE holds PC without run
    reset = 1'b0;
    tick();
    check("idle_pc", 32'(direinstru), 32'd0);
    check("idle_valid", 32'(instr_valid), 32'd0);

    // Redirect in IDLE moves PC but does not start fetching
    redirect_valid = 1'b1; redirect_addr = 5'd7; run = 1'b1;
    tick();
    check("idle_redir_pc", 32'(direinstru), 32'd7);
    redirect_addr = 5'd0; run = 1'b0;
    tick();
    check("idle_redir_pc0", 32'(direinstru), 32'd0);
    check("idle_redir_valid", 32'(instr_valid), 32'd0);

    // Enter FETCH, then words 1..5 on consecutive cycles
    redirect_valid = 1'b0; run = 1'b1;
    tick();
    check("fetch_entry_valid", 32'(instr_valid), 32'd0);
    check("fetch_entry_pc", 32'(direinstru), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("seq_out", instr_out, 32'(k));
      check("seq_valid", 32'(instr_valid), 32'd1);
      check("seq_pc", 32'(direinstru), 32'(k));
    end
    check("seq_count", 32'(fetch_count), 32'd5);

    // Back-pressure for 3 cycles holds everything
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_out", instr_out, 32'd5);
      check("stall_pc", 32'(direinstru), 32'd5);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    check("resume_out", instr_out, 32'd6);
    check("resume_pc", 32'(direinstru), 32'd6);
    check("resume_count", 32'(fetch_count), 32'd6);
    tick();
    check("resume2_out", instr_out, 32'd7);
    check("resume2_count", 32'(fetch_count), 32'd7);

    // Redirect in the same cycle as a handshake with a jump word captured
    mem[7] = jword(5'd2);
    redirect_valid = 1'b1; redirect_addr = 5'd20;
    tick();
    check("redir_pc", 32'(direinstru), 32'd20);
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_count", 32'(fetch_count), 32'd7);
    redirect_valid = 1'b0;
    tick();
    check("after_redir_out", instr_out, 32'd21);
    check("after_redir_pc", 32'(direinstru), 32'd21);
    check("after_redir_count", 32'(fetch_count), 32'd8);

    // Jump word at address 3 with imm=+2
    mem[3] = jword(5'd2);
    redirect_valid = 1'b1; redirect_addr = 5'd3;
    tick();
    redirect_valid = 1'b0;
    check("jmp_setup_pc", 32'(direinstru), 32'd3);
`ifdef FETCH_RELATIVE_JUMP_EN
    tick();
    check("jmp_valid", 32'(instr_valid), 32'd0);
    check("jmp_pc", 32'(direinstru), 32'd5);
    check("jmp_count", 32'(fetch_count), 32'd8);
    tick();
    check("jmp_tgt_out", instr_out, 32'd6);
    check("jmp_tgt_count", 32'(fetch_count), 32'd9);
    // Backward jump at address 1 with imm=-3 lands on 30
    mem[1] = jword(5'b11101);
    redirect_valid = 1'b1; redirect_addr = 5'd1;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("jmpneg_pc", 32'(direinstru), 32'd30);
    check("jmpneg_valid", 32'(instr_valid), 32'd0);
    check("jmpneg_count", 32'(fetch_count), 32'd9);
`else
    tick();
    check("jmp_issued_out", instr_out, jword(5'd2));
    check("jmp_issued_valid", 32'(instr_valid), 32'd1);
    check("jmp_issued_pc", 32'(direinstru), 32'd4);
    check("jmp_issued_count", 32'(fetch_count), 32'd9);
    redirect_valid = 1'b1; redirect_addr = 5'd30;
    tick();
    redirect_valid = 1'b0;
    check("to30_pc", 32'(direinstru), 32'd30);
    check("to30_valid", 32'(instr_valid), 32'd0);
`endif
    tick();
    check("a30_out", instr_out, 32'd31);
    check("a30_pc", 32'(direinstru), 32'd31);
    check("a30_count", 32'(fetch_count), 32'd10);
    tick();
    check("wrap_out", instr_out, 32'd32);
    check("wrap_pc", 32'(direinstru), 32'd0);
    check("wrap_count", 32'(fetch_count), 32'd11);

    // HALT_WORD at address 9
    redirect_valid = 1'b1; redirect_addr = 5'd8;
    tick();
    redirect_valid = 1'b0;
    check("halt_setup_pc", 32'(direinstru), 32'd8);
    mem[9] = 32'h0000_0000;
    tick();
    check("pre_halt_out", instr_out, 32'd9);
    check("pre_halt_pc", 32'(direinstru), 32'd9);
    check("pre_halt_count", 32'(fetch_count), 32'd12);
    tick();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_pc", 32'(direinstru), 32'd9);
    check("halt_count", 32'(fetch_count), 32'd12);
    redirect_valid = 1'b1; redirect_addr = 5'd4;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("halt_redir_halted", 32'(halted), 32'd1);
    check("halt_redir_pc", 32'(direinstru), 32'd9);
    check("halt_redir_valid", 32'(instr_valid), 32'd0);

    // Reset leaves HALT
    reset = 1'b1;
    tick();
    check("rst2_pc", 32'(direinstru), 32'd0);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_count", 32'(fetch_count), 32'd0);
    check("rst2_out", instr_out, 32'd0);
    reset = 1'b0; run = 1'b0;
    tick();
    check("rst2_idle_pc", 32'(direinstru), 32'd0);

    // Reset while an instruction is held discards it
    run = 1'b1; instr_ready = 1'b0;
    tick();
    tick();
    check("held_out", instr_out, 32'd1);
    check("held_valid", 32'(instr_valid), 32'd1);
    tick();
    check("held_pc", 32'(direinstru), 32'd1);
    reset = 1'b1;
    tick();
    check("rst3_valid", 32'(instr_valid), 32'd0);
    check("rst3_count", 32'(fetch_count), 32'd0);
    check("rst3_pc", 32'(direinstru), 32'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
